// File: rtl/cpu_timing_ctrl_if.sv
// Signal bundle between the CPU timing controller (master) and the Z80 wrapper /
// memory mapper side (slave).
interface cpu_timing_ctrl_if;
    logic       mreq;
    logic       contend;
    logic       pe;
    logic       ne;
    logic       irq;
    logic       hold;
    logic [7:0] hcount;
    logic [8:0] vcount;

    modport master (
        input  mreq, contend,
        output pe, ne, irq, hold, hcount, vcount
    );

    modport slave (
        output mreq, contend,
        input  pe, ne, irq, hold, hcount, vcount
    );
endinterface

// File: rtl/cpu_timing_ctrl.sv
// Z80 clock-enable sequencer, frame T-state counters, 50 Hz irq and +3-style memory
// contention. Contention is built only when CONTENTION_EN is defined.
module cpu_timing_ctrl #(
    parameter int DIV        = 8,
    parameter int HTOT       = 228,
    parameter int VTOT       = 311,
    parameter int IRQ_LEN    = 32,
    parameter int CONT_V0    = 63,
    parameter int CONT_LINES = 192,
    parameter int CONT_HLEN  = 128
) (
    input  logic              clock,
    input  logic              reset,
    cpu_timing_ctrl_if.master bus
);
    localparam int CW = $clog2(DIV);

    logic [CW-1:0] c;
    logic          tick;
    logic          half;
    logic [7:0]    h_nxt;
    logic [8:0]    v_nxt;

    assign tick = (c == CW'(DIV - 1));
    assign half = (c == CW'(DIV / 2 - 1));

    always_comb begin
        h_nxt = bus.hcount + 8'd1;
        v_nxt = bus.vcount;
        if (bus.hcount == 8'(HTOT - 1)) begin
            h_nxt = 8'd0;
            v_nxt = (bus.vcount == 9'(VTOT - 1)) ? 9'd0 : bus.vcount + 9'd1;
        end
    end

    // Video timing never stretches: counters advance on every boundary, held or not.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            c          <= '0;
            bus.hcount <= 8'd0;
            bus.vcount <= 9'd0;
            bus.pe     <= 1'b0;
            bus.ne     <= 1'b0;
            bus.irq    <= 1'b1;
        end else begin
            c       <= tick ? '0 : c + 1'b1;
            bus.pe  <= tick && !bus.hold;
            bus.ne  <= half && !bus.hold;
            bus.irq <= !(bus.vcount == 9'd0 && bus.hcount < 8'(IRQ_LEN));
            if (tick) begin
                bus.hcount <= h_nxt;
                bus.vcount <= v_nxt;
            end
        end
    end

`ifdef CONTENTION_EN
    logic granted;
    logic in_win;
    logic hold_nxt;

    // Decision is made for the T-state being entered, hence h_nxt/v_nxt.
    always_comb begin
        in_win   = (v_nxt >= 9'(CONT_V0)) &&
                   (v_nxt <= 9'(CONT_V0 + CONT_LINES - 1)) &&
                   (h_nxt < 8'(CONT_HLEN));
        hold_nxt = !bus.mreq && bus.contend && !granted && in_win &&
                   (h_nxt[2:0] != 3'd1);
    end

    // granted limits each memory cycle to a single penalty; the CPU is frozen while
    // held, so mreq stays low until the access completes.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.hold <= 1'b0;
            granted  <= 1'b0;
        end else if (tick) begin
            bus.hold <= hold_nxt;
            if (bus.mreq)
                granted <= 1'b0;
            else if (bus.contend && !hold_nxt)
                granted <= 1'b1;
        end
    end
`else
    assign bus.hold = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_timing_ctrl.sv
// Scoreboard bench for cpu_timing_ctrl using shrunk frame geometry so several
// frames fit in a short run; contention expectations follow CONTENTION_EN.
module tb_cpu_timing_ctrl;
    localparam int DIV        = 8;
    localparam int HTOT       = 16;
    localparam int VTOT       = 8;
    localparam int IRQ_LEN    = 4;
    localparam int CONT_V0    = 3;
    localparam int CONT_LINES = 2;
    localparam int CONT_HLEN  = 12;
`ifdef CONTENTION_EN
    localparam int EXP_HOLDS  = 4;
`else
    localparam int EXP_HOLDS  = 0;
`endif

    typedef struct { int h0; int v0; int clks; int h1; int pes; int nes; } hold_ev_t;
    typedef struct { int fall; int h; int v; int len; } irq_ev_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    cpu_timing_ctrl_if bus();

    cpu_timing_ctrl #(
        .DIV(DIV), .HTOT(HTOT), .VTOT(VTOT), .IRQ_LEN(IRQ_LEN),
        .CONT_V0(CONT_V0), .CONT_LINES(CONT_LINES), .CONT_HLEN(CONT_HLEN)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard queues filled by the stimulus, drained by the monitor.
    int       exp_pe[$];
    int       exp_ne[$];
    hold_ev_t exp_hold[$];
    irq_ev_t  exp_irq[$];
    bit       track_pe = 1'b0;
    int       cyc = 0;
    int       n_hold = 0;
    hold_ev_t cur;
    irq_ev_t  icur;
    logic     hold_d = 1'b0;
    logic     irq_d = 1'b1;

    always @(negedge clock) begin
        hold_ev_t e;
        irq_ev_t  ie;
        if (reset) cyc = 0;
        else       cyc++;

        if (track_pe && bus.pe) begin
            if (exp_pe.size() == 0) chk("pe_unexpected", cyc, -1);
            else                    chk("pe_cycle", cyc, exp_pe.pop_front());
        end
        if (track_pe && bus.ne) begin
            if (exp_ne.size() == 0) chk("ne_unexpected", cyc, -1);
            else                    chk("ne_cycle", cyc, exp_ne.pop_front());
        end

        if (hold_d && bus.pe) cur.pes++;
        if (hold_d && bus.ne) cur.nes++;
        if (bus.hold && !hold_d) begin
            n_hold++;
            cur = '{int'(bus.hcount), int'(bus.vcount), 0, 0, 0, 0};
        end
        if (bus.hold) cur.clks++;
        if (!bus.hold && hold_d) begin
            cur.h1 = int'(bus.hcount);
            if (exp_hold.size() == 0) chk("hold_unexpected", cur.h0, -1);
            else begin
                e = exp_hold.pop_front();
                chk("hold_h0", cur.h0, e.h0);
                chk("hold_v0", cur.v0, e.v0);
                chk("hold_clks", cur.clks, e.clks);
                chk("hold_release_h", cur.h1, e.h1);
                chk("hold_pe_count", cur.pes, e.pes);
                chk("hold_ne_count", cur.nes, e.nes);
            end
        end
        hold_d = bus.hold;

        if (!bus.irq && irq_d) icur = '{cyc, int'(bus.hcount), int'(bus.vcount), 0};
        if (!bus.irq) icur.len++;
        if (bus.irq && !irq_d && exp_irq.size() != 0) begin
            ie = exp_irq.pop_front();
            chk("irq_fall_cycle", icur.fall, ie.fall);
            chk("irq_fall_h", icur.h, ie.h);
            chk("irq_fall_v", icur.v, ie.v);
            chk("irq_len", icur.len, ie.len);
        end
        irq_d = bus.irq;
    end

    task automatic goto(input int v, input int h);
        bit hit = 1'b0;
        for (int n = 0; n < 4000 && !hit; n++) begin
            @(negedge clock);
            hit = (int'(bus.vcount) == v) && (int'(bus.hcount) == h);
        end
        if (!hit) chk("goto_timeout", 0, 1);
    endtask

    task automatic wait_h(input int h);
        bit hit = 1'b0;
        for (int n = 0; n < 100 && !hit; n++) begin
            @(negedge clock);
            hit = (int'(bus.hcount) == h);
        end
        if (!hit) chk("wait_h_timeout", 0, 1);
    endtask

    // Present an access so that the T-state entering (v,h) sees it, then end it
    // `extra` T-states after any hold releases.
    task automatic access(input int v, input int h, input logic m, input logic c,
                          input int extra);
        goto(v, h - 1);
        bus.mreq    = m;
        bus.contend = c;
        wait_h(h);
        for (int n = 0; n < 200 && bus.hold; n++) @(negedge clock);
        if (bus.hold) chk("release_timeout", 0, 1);
        repeat (extra * DIV) @(negedge clock);
        bus.mreq    = 1'b1;
        bus.contend = 1'b0;
    endtask

    initial begin
        bus.mreq    = 1'b1;
        bus.contend = 1'b0;
        exp_irq.push_back('{1, 0, 0, IRQ_LEN * DIV});
        exp_irq.push_back('{1 + HTOT * VTOT * DIV, 0, 0, IRQ_LEN * DIV});
        for (int k = 1; k <= 3; k++) begin
            exp_pe.push_back(k * DIV);
            exp_ne.push_back(k * DIV - DIV / 2);
        end
        track_pe = 1'b1;

        repeat (3) @(negedge clock);
        chk("reset_pe", bus.pe, 0);
        chk("reset_ne", bus.ne, 0);
        chk("reset_hold", bus.hold, 0);
        chk("reset_irq", bus.irq, 1);
        chk("reset_hcount", bus.hcount, 0);
        chk("reset_vcount", bus.vcount, 0);
        @(negedge clock);
        #1 reset = 1'b0;

        repeat (26) @(negedge clock);
        #1 track_pe = 1'b0;
        chk("pe_q_left", exp_pe.size(), 0);
        chk("ne_q_left", exp_ne.size(), 0);
        repeat (94) @(negedge clock);
        chk("hcount_last", bus.hcount, HTOT - 1);
        chk("vcount_line0", bus.vcount, 0);
        repeat (8) @(negedge clock);
        chk("hcount_wrap", bus.hcount, 0);
        chk("vcount_inc", bus.vcount, 1);

`ifdef CONTENTION_EN
        exp_hold.push_back('{2, 3, 7 * DIV, 9, 0, 0});
`endif
        access(3, 2, 1'b0, 1'b1, 2);
        access(3, 13, 1'b0, 1'b1, 1);
`ifdef CONTENTION_EN
        exp_hold.push_back('{8, 4, DIV, 9, 0, 0});
`endif
        access(4, 8, 1'b0, 1'b1, 1);
        access(3, 9, 1'b0, 1'b1, 2);
`ifdef CONTENTION_EN
        exp_hold.push_back('{10, 4, 2 * DIV, 12, 0, 0});
`endif
        access(4, 10, 1'b0, 1'b1, 1);
        access(1, 2, 1'b0, 1'b1, 1);
        access(3, 2, 1'b0, 1'b0, 1);
        access(3, 6, 1'b1, 1'b1, 1);

        // Reset in the middle of a 5-T-state hold entered at phase 4.
`ifdef CONTENTION_EN
        exp_hold.push_back('{4, 4, 20, 0, 0, 0});
`endif
        goto(4, 3);
        bus.mreq    = 1'b0;
        bus.contend = 1'b1;
        wait_h(4);
        repeat (19) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("async_pe", bus.pe, 0);
        chk("async_ne", bus.ne, 0);
        chk("async_hold", bus.hold, 0);
        chk("async_irq", bus.irq, 1);
        chk("async_hcount", bus.hcount, 0);
        chk("async_vcount", bus.vcount, 0);
        bus.mreq    = 1'b1;
        bus.contend = 1'b0;
        @(negedge clock);
        #1 reset = 1'b0;
        repeat (7) @(negedge clock);
        chk("restart_pe_early", bus.pe, 0);
        @(negedge clock);
        chk("restart_pe", bus.pe, 1);
        chk("restart_hcount", bus.hcount, 1);
        chk("restart_vcount", bus.vcount, 0);
        repeat (4) @(negedge clock);

        chk("hold_count", n_hold, EXP_HOLDS);
        chk("hold_q_left", exp_hold.size(), 0);
        chk("irq_q_left", exp_irq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
